// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and
// a saturating count of inserted bubbles.
module id_ex_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_ext_i,
    input  logic        flush_i,
    input  logic        ID_valid_i,
    input  logic [4:0]  ID_RS_i,
    input  logic [4:0]  ID_RT_i,
    input  logic [4:0]  ID_RD_i,
    input  logic        ID_UsesRT_i,
    input  logic        ID_RegWrite_i,
    input  logic        ID_MemRead_i,
    input  logic        ID_MemWrite_i,
    input  logic        ID_MemtoReg_i,
    input  logic        ID_ALUSrc_i,
    input  logic        ID_RegDst_i,
    input  logic [1:0]  ID_ALUOp_i,
    input  logic [31:0] ID_Data1_i,
    input  logic [31:0] ID_Data2_i,
    input  logic [31:0] ID_Imm_i,
    output logic        IDEX_valid_o,
    output logic [4:0]  IDEX_RS_o,
    output logic [4:0]  IDEX_RT_o,
    output logic [4:0]  IDEX_RD_o,
    output logic        IDEX_RegWrite_o,
    output logic        IDEX_MemRead_o,
    output logic        IDEX_MemWrite_o,
    output logic        IDEX_MemtoReg_o,
    output logic        IDEX_ALUSrc_o,
    output logic        IDEX_RegDst_o,
    output logic [1:0]  IDEX_ALUOp_o,
    output logic [31:0] IDEX_Data1_o,
    output logic [31:0] IDEX_Data2_o,
    output logic [31:0] IDEX_Imm_o,
    output logic        Hazard_o,
    output logic [15:0] bubble_cnt_o
);

    // Hold/bubble protocol: stall_ext_i freezes every register including the
    // counter; flush_i or a load-use hit replaces the EX slot with a bubble;
    // Hazard_o asks PC and IF/ID to hold for exactly the one bubble cycle.
    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_HOLD,
        ACT_SQUASH,
        ACT_BUBBLE,
        ACT_LOAD
    } action_e;

    logic        lu;
    logic        rt_hit_rs;
    logic        rt_hit_rt;
    logic        load_ctrl;
    action_e     action;
    logic [15:0] bubble_cnt_q;

    always_comb begin
        rt_hit_rs = (IDEX_RT_o == ID_RS_i);
        rt_hit_rt = ID_UsesRT_i & (IDEX_RT_o == ID_RT_i);
        lu        = IDEX_valid_o & IDEX_MemRead_o & ID_valid_i &
                    (IDEX_RT_o != 5'd0) & (rt_hit_rs | rt_hit_rt);
    end

    assign Hazard_o = lu & ~flush_i & ~stall_ext_i & ~rst_i;

    always_comb begin
        action = ACT_LOAD;
        if (rst_i)            action = ACT_RESET;
        else if (stall_ext_i) action = ACT_HOLD;
        else if (flush_i)     action = ACT_SQUASH;
        else if (lu)          action = ACT_BUBBLE;
    end

    // An invalid slot must never carry live write or memory controls.
    assign load_ctrl = ID_valid_i;

    always_ff @(posedge clk_i) begin
        case (action)
            ACT_RESET, ACT_SQUASH, ACT_BUBBLE: begin
                IDEX_valid_o    <= 1'b0;
                IDEX_RS_o       <= 5'd0;
                IDEX_RT_o       <= 5'd0;
                IDEX_RD_o       <= 5'd0;
                IDEX_RegWrite_o <= 1'b0;
                IDEX_MemRead_o  <= 1'b0;
                IDEX_MemWrite_o <= 1'b0;
                IDEX_MemtoReg_o <= 1'b0;
                IDEX_ALUSrc_o   <= 1'b0;
                IDEX_RegDst_o   <= 1'b0;
                IDEX_ALUOp_o    <= 2'd0;
                IDEX_Data1_o    <= 32'd0;
                IDEX_Data2_o    <= 32'd0;
                IDEX_Imm_o      <= 32'd0;
            end
            ACT_LOAD: begin
                IDEX_valid_o    <= ID_valid_i;
                IDEX_RS_o       <= ID_RS_i;
                IDEX_RT_o       <= ID_RT_i;
                IDEX_RD_o       <= ID_RD_i;
                IDEX_RegWrite_o <= ID_RegWrite_i & load_ctrl;
                IDEX_MemRead_o  <= ID_MemRead_i  & load_ctrl;
                IDEX_MemWrite_o <= ID_MemWrite_i & load_ctrl;
                IDEX_MemtoReg_o <= ID_MemtoReg_i & load_ctrl;
                IDEX_ALUSrc_o   <= ID_ALUSrc_i   & load_ctrl;
                IDEX_RegDst_o   <= ID_RegDst_i   & load_ctrl;
                IDEX_ALUOp_o    <= ID_ALUOp_i & {2{load_ctrl}};
                IDEX_Data1_o    <= ID_Data1_i;
                IDEX_Data2_o    <= ID_Data2_i;
                IDEX_Imm_o      <= ID_Imm_i;
            end
            default: begin
            end
        endcase
    end

    // Only real load-use bubbles are counted; flush squashes are not.
    always_ff @(posedge clk_i) begin
        if (action == ACT_RESET) begin
            bubble_cnt_q <= 16'd0;
        end else if (action == ACT_BUBBLE && bubble_cnt_q != 16'hFFFF) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed table of pipeline scenarios, randomized
// traffic against a behavioural model, and a counter saturation sequence.
module tb_id_ex_stage;

  localparam int W = 136;
  localparam logic [7:0] C_ADD  = 8'h86;
  localparam logic [7:0] C_LW   = 8'hD8;
  localparam logic [7:0] C_ADDI = 8'h88;

  // ctrl = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp[1:0]}
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        uses_rt;
    logic [7:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
  } instr_t;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    instr_t      in;
    logic        exp_h;
    logic        exp_valid;
    logic [4:0]  exp_rs;
    logic [7:0]  exp_ctrl;
    logic [15:0] exp_cnt;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, stall_ext_i, flush_i;
  logic        ID_valid_i, ID_UsesRT_i;
  logic [4:0]  ID_RS_i, ID_RT_i, ID_RD_i;
  logic        ID_RegWrite_i, ID_MemRead_i, ID_MemWrite_i, ID_MemtoReg_i;
  logic        ID_ALUSrc_i, ID_RegDst_i;
  logic [1:0]  ID_ALUOp_i;
  logic [31:0] ID_Data1_i, ID_Data2_i, ID_Imm_i;
  logic        IDEX_valid_o;
  logic [4:0]  IDEX_RS_o, IDEX_RT_o, IDEX_RD_o;
  logic        IDEX_RegWrite_o, IDEX_MemRead_o, IDEX_MemWrite_o, IDEX_MemtoReg_o;
  logic        IDEX_ALUSrc_o, IDEX_RegDst_o;
  logic [1:0]  IDEX_ALUOp_o;
  logic [31:0] IDEX_Data1_o, IDEX_Data2_o, IDEX_Imm_o;
  logic        Hazard_o;
  logic [15:0] bubble_cnt_o;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst_i), .stall_ext_i(stall_ext_i), .flush_i(flush_i),
    .ID_valid_i(ID_valid_i), .ID_RS_i(ID_RS_i), .ID_RT_i(ID_RT_i), .ID_RD_i(ID_RD_i),
    .ID_UsesRT_i(ID_UsesRT_i), .ID_RegWrite_i(ID_RegWrite_i), .ID_MemRead_i(ID_MemRead_i),
    .ID_MemWrite_i(ID_MemWrite_i), .ID_MemtoReg_i(ID_MemtoReg_i), .ID_ALUSrc_i(ID_ALUSrc_i),
    .ID_RegDst_i(ID_RegDst_i), .ID_ALUOp_i(ID_ALUOp_i), .ID_Data1_i(ID_Data1_i),
    .ID_Data2_i(ID_Data2_i), .ID_Imm_i(ID_Imm_i),
    .IDEX_valid_o(IDEX_valid_o), .IDEX_RS_o(IDEX_RS_o), .IDEX_RT_o(IDEX_RT_o),
    .IDEX_RD_o(IDEX_RD_o), .IDEX_RegWrite_o(IDEX_RegWrite_o), .IDEX_MemRead_o(IDEX_MemRead_o),
    .IDEX_MemWrite_o(IDEX_MemWrite_o), .IDEX_MemtoReg_o(IDEX_MemtoReg_o),
    .IDEX_ALUSrc_o(IDEX_ALUSrc_o), .IDEX_RegDst_o(IDEX_RegDst_o), .IDEX_ALUOp_o(IDEX_ALUOp_o),
    .IDEX_Data1_o(IDEX_Data1_o), .IDEX_Data2_o(IDEX_Data2_o), .IDEX_Imm_o(IDEX_Imm_o),
    .Hazard_o(Hazard_o), .bubble_cnt_o(bubble_cnt_o)
  );

  // ---------------- scoreboard / model state ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  instr_t cur;
  instr_t m_idex;
  int unsigned m_cnt;
  vec_t tbl[26];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] dut_ctrl();
    return {IDEX_RegWrite_o, IDEX_MemRead_o, IDEX_MemWrite_o, IDEX_MemtoReg_o,
            IDEX_ALUSrc_o, IDEX_RegDst_o, IDEX_ALUOp_o};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {IDEX_valid_o, IDEX_RS_o, IDEX_RT_o, IDEX_RD_o, dut_ctrl(),
            IDEX_Data1_o, IDEX_Data2_o, IDEX_Imm_o, bubble_cnt_o};
  endfunction

  function automatic logic [W-1:0] model_vec();
    return {m_idex.valid, m_idex.rs, m_idex.rt, m_idex.rd, m_idex.ctrl,
            m_idex.d1, m_idex.d2, m_idex.imm, m_cnt[15:0]};
  endfunction

  // Load in EX whose destination (non-zero) is a source of the ID instruction.
  function automatic logic model_lu();
    logic rs_dep, rt_dep;
    rs_dep = (m_idex.rt == cur.rs);
    rt_dep = cur.uses_rt && (m_idex.rt == cur.rt);
    return m_idex.valid && m_idex.ctrl[6] && cur.valid && (m_idex.rt != 0) && (rs_dep || rt_dep);
  endfunction

  function automatic instr_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic ur, input logic [7:0] ctrl);
    instr_t t;
    t.valid = v; t.rs = rs; t.rt = rt; t.rd = rd; t.uses_rt = ur; t.ctrl = ctrl;
    t.d1 = $urandom; t.d2 = $urandom; t.imm = $urandom;
    return t;
  endfunction

  function automatic vec_t tv(input logic r, input logic s, input logic f, input instr_t in,
                              input logic h, input logic v, input logic [4:0] rs,
                              input logic [7:0] c, input logic [15:0] cnt);
    vec_t x;
    x.rst = r; x.stall = s; x.flush = f; x.in = in;
    x.exp_h = h; x.exp_valid = v; x.exp_rs = rs; x.exp_ctrl = c; x.exp_cnt = cnt;
    return x;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic s, input logic f, input instr_t in);
    rst_i = r; stall_ext_i = s; flush_i = f;
    cur = in;
    ID_valid_i = in.valid; ID_RS_i = in.rs; ID_RT_i = in.rt; ID_RD_i = in.rd;
    ID_UsesRT_i = in.uses_rt;
    {ID_RegWrite_i, ID_MemRead_i, ID_MemWrite_i, ID_MemtoReg_i,
     ID_ALUSrc_i, ID_RegDst_i, ID_ALUOp_i} = in.ctrl;
    ID_Data1_i = in.d1; ID_Data2_i = in.d2; ID_Imm_i = in.imm;
  endtask

  // One clock: check Hazard_o before the edge, advance the model, check after.
  task automatic cycle(input string nm, output logic h_seen);
    logic lu, exp_h;
    #2;
    lu = model_lu();
    exp_h = lu && !flush_i && !stall_ext_i && !rst_i;
    h_seen = Hazard_o;
    chk({nm, " model hazard"}, {{(W-1){1'b0}}, Hazard_o}, {{(W-1){1'b0}}, exp_h});
    if (rst_i) begin
      m_idex = '0;
      m_cnt = 0;
    end else if (stall_ext_i) begin
      m_idex = m_idex;
    end else if (flush_i || lu) begin
      m_idex = '0;
      if (!flush_i && m_cnt < 65535) m_cnt++;
    end else begin
      m_idex = cur;
      m_idex.uses_rt = 1'b0;
      if (!cur.valid) m_idex.ctrl = 8'h00;
    end
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    chk({nm, " model regs"}, dut_vec(), exp_q.pop_front());
  endtask

  // ---------------- test ----------------
  initial begin
    logic h;
    instr_t rnd;
    m_idex = '0;
    m_cnt = 0;
    drive(1'b1, 1'b0, 1'b0, mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 8'h00));

    tbl[0]  = tv(1,0,0, mk(1, 1, 2, 3,1,C_ADD),  0,0, 0,8'h00,0);
    tbl[1]  = tv(0,0,0, mk(1, 1, 2, 3,1,C_ADD),  0,1, 1,C_ADD,0);
    tbl[2]  = tv(0,0,0, mk(1, 1, 5, 0,0,C_LW),   0,1, 1,C_LW, 0);
    tbl[3]  = tv(0,0,0, mk(1, 5, 2, 6,1,C_ADD),  1,0, 0,8'h00,1);
    tbl[4]  = tv(0,0,0, tbl[3].in,               0,1, 5,C_ADD,1);
    tbl[5]  = tv(0,0,0, mk(1, 2, 5, 0,0,C_LW),   0,1, 2,C_LW, 1);
    tbl[6]  = tv(0,0,0, mk(1, 1, 5, 0,0,C_ADDI), 0,1, 1,C_ADDI,1);
    tbl[7]  = tv(0,0,0, mk(1, 3, 0, 0,0,C_LW),   0,1, 3,C_LW, 1);
    tbl[8]  = tv(0,0,0, mk(1, 0, 0, 4,1,C_ADD),  0,1, 0,C_ADD,1);
    tbl[9]  = tv(0,0,0, mk(1, 4, 7, 0,0,C_LW),   0,1, 4,C_LW, 1);
    tbl[10] = tv(0,0,1, mk(1, 7, 1, 2,1,C_ADD),  0,0, 0,8'h00,1);
    tbl[11] = tv(0,0,0, mk(1, 4, 8, 0,0,C_LW),   0,1, 4,C_LW, 1);
    tbl[12] = tv(0,1,0, mk(1, 8, 1, 2,1,C_ADD),  0,1, 4,C_LW, 1);
    tbl[13] = tv(0,1,0, tbl[12].in,              0,1, 4,C_LW, 1);
    tbl[14] = tv(0,1,0, tbl[12].in,              0,1, 4,C_LW, 1);
    tbl[15] = tv(0,0,0, tbl[12].in,              1,0, 0,8'h00,2);
    tbl[16] = tv(0,0,0, tbl[12].in,              0,1, 8,C_ADD,2);
    tbl[17] = tv(0,0,0, mk(1, 1, 9, 0,0,C_LW),   0,1, 1,C_LW, 2);
    tbl[18] = tv(0,0,0, mk(1, 9,10, 0,0,C_LW),   1,0, 0,8'h00,3);
    tbl[19] = tv(0,0,0, tbl[18].in,              0,1, 9,C_LW, 3);
    tbl[20] = tv(0,0,0, mk(1,10, 3, 4,1,C_ADD),  1,0, 0,8'h00,4);
    tbl[21] = tv(0,0,0, tbl[20].in,              0,1,10,C_ADD,4);
    tbl[22] = tv(0,0,0, mk(0, 3, 4, 5,1,8'hE6),  0,0, 3,8'h00,4);
    tbl[23] = tv(0,0,0, mk(1, 2,11, 0,0,C_LW),   0,1, 2,C_LW, 4);
    tbl[24] = tv(1,0,0, mk(1,11, 1, 2,1,C_ADD),  0,0, 0,8'h00,0);
    tbl[25] = tv(0,0,0, tbl[24].in,              0,1,11,C_ADD,0);

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].in);
      cycle($sformatf("row%0d", i), h);
      chk($sformatf("row%0d hazard", i), {{(W-1){1'b0}}, h}, {{(W-1){1'b0}}, tbl[i].exp_h});
      chk($sformatf("row%0d valid/rs/ctrl/cnt", i),
          {{(W-30){1'b0}}, IDEX_valid_o, IDEX_RS_o, dut_ctrl(), bubble_cnt_o},
          {{(W-30){1'b0}}, tbl[i].exp_valid, tbl[i].exp_rs, tbl[i].exp_ctrl, tbl[i].exp_cnt});
    end

    // Randomized traffic with dense register reuse so load-use hits are common.
    for (int i = 0; i < 3000; i++) begin
      rnd = mk($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom));
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, rnd);
      cycle("rand", h);
    end

    // Saturation: preload the counter near its top, then two more hazards.
    drive(1'b1, 1'b0, 1'b0, mk(1, 1, 2, 3, 1, C_ADD));
    cycle("sat reset", h);
    drive(1'b0, 1'b0, 1'b0, mk(1, 1, 2, 3, 1, C_ADD));
    force dut.bubble_cnt_q = 16'hFFFE;
    #1;
    release dut.bubble_cnt_q;
    m_cnt = 16'hFFFE;
    cycle("sat preload", h);
    drive(1'b0, 1'b0, 1'b0, mk(1, 1, 5, 0, 0, C_LW));
    cycle("sat lw1", h);
    drive(1'b0, 1'b0, 1'b0, mk(1, 5, 2, 6, 1, C_ADD));
    cycle("sat hz1", h);
    chk("sat reach max", {{(W-16){1'b0}}, bubble_cnt_o}, {{(W-16){1'b0}}, 16'hFFFF});
    cycle("sat add1", h);
    drive(1'b0, 1'b0, 1'b0, mk(1, 2, 6, 0, 0, C_LW));
    cycle("sat lw2", h);
    drive(1'b0, 1'b0, 1'b0, mk(1, 3, 6, 7, 1, C_ADD));
    cycle("sat hz2", h);
    chk("sat hz2 hazard", {{(W-1){1'b0}}, h}, {{(W-1){1'b0}}, 1'b1});
    chk("sat hold max", {{(W-16){1'b0}}, bubble_cnt_o}, {{(W-16){1'b0}}, 16'hFFFF});
    cycle("sat add2", h);
    drive(1'b0, 1'b0, 1'b0, mk(1, 2, 7, 0, 0, C_LW));
    cycle("sat lw3", h);
    drive(1'b1, 1'b0, 1'b0, mk(1, 7, 1, 2, 1, C_ADD));
    cycle("sat rst in hazard", h);
    chk("rst in hazard clears all", dut_vec(), {W{1'b0}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk_i  in  1  clock, rising-edge; rst_i  in  1  reset, synchronous, active-high.
REQ-002 SHALL have: stall_ext_i  in  1  global hold, e.g. memory wait; flush_i  in  1  branch-taken squash of the ID instruction.
REQ-003 SHALL have: ID_valid_i  in  1  ID holds a real instruction; ID_RS_i, ID_RT_i, ID_RD_i  in  5 each  register specifiers; ID_UsesRT_i  in  1  instruction reads RT as a source.
REQ-004 SHALL have: ID_RegWrite_i, ID_MemRead_i, ID_MemWrite_i, ID_MemtoReg_i, ID_ALUSrc_i, ID_RegDst_i  in  1 each; ID_ALUOp_i  in  2.
REQ-005 SHALL have: ID_Data1_i, ID_Data2_i, ID_Imm_i  in  32 each  register-file reads and sign-extended immediate.
REQ-006 SHALL have outputs IDEX_valid_o, IDEX_RS_o, IDEX_RT_o, IDEX_RD_o, IDEX_<ctrl>_o, IDEX_Data1_o, IDEX_Data2_o, IDEX_Imm_o: registered copies, same widths as the inputs; these feed EX and the forwarding unit.
REQ-007 SHALL have: Hazard_o  out  1  combinational load-use stall request to PC and IF/ID (hold both); bubble_cnt_o  out  16  count of hazard bubbles inserted.

Function
REQ-008 Load-use detect (combinational): lu = IDEX_valid_o & IDEX_MemRead_o & ID_valid_i & (IDEX_RT_o != 0) & ((IDEX_RT_o == ID_RS_i) | (ID_UsesRT_i & IDEX_RT_o == ID_RT_i)).
REQ-009 Hazard_o SHALL equal lu & ~flush_i & ~stall_ext_i & ~rst_i.
REQ-010 Per-edge priority SHALL be: rst_i > stall_ext_i > flush_i > lu > normal load.
REQ-011 stall_ext_i=1: every register, including bubble_cnt_o, SHALL hold its value.
REQ-012 flush_i=1 (no stall_ext): IDEX_valid_o and all seven control outputs SHALL clear to 0; specifier and data outputs don't care, and SHALL be cleared to 0.
REQ-013 lu=1 (no flush, no stall_ext): bubble inserted as in REQ-012; bubble_cnt_o increments by 1, saturating at 16'hFFFF; IF/ID contents preserved upstream via Hazard_o.
REQ-014 Normal: all IDEX outputs SHALL load the ID inputs in one cycle (latency 1); IDEX_valid_o <= ID_valid_i.
REQ-015 ID_valid_i=0 on load: controls SHALL be forced to 0 regardless of ID_<ctrl>_i; no instruction with valid=0 may write regs or memory.
REQ-016 Load-use stall SHALL last exactly one cycle: the bubble clears IDEX_MemRead_o, so lu drops on the next cycle and the held instruction enters EX.
REQ-017 Back-to-back loads each with a dependent consumer SHALL each produce one independent bubble.
REQ-018 Load writing $0 (IDEX_RT_o=0) SHALL never stall.

Reset
REQ-019 On rst_i=1 at a clock edge: all IDEX outputs and bubble_cnt_o SHALL become 0, overriding stall_ext_i, flush_i and lu.
REQ-020 Hazard_o SHALL be 0 while rst_i=1 and in the cycle after release, since IDEX_valid_o=0.
REQ-021 Reset asserted mid-stall SHALL discard the pending bubble; no increment of bubble_cnt_o.

Verification
REQ-022 Normal flow: ID add $3,$1,$2 (RS=1,RT=2,RD=3,RegWrite=1), valid -> next cycle IDEX_RS_o=1, RT=2, RD=3, RegWrite=1, Hazard_o=0.
REQ-023 Load-use: IDEX holds lw $5 (MemRead=1,RT=5), ID holds add RS=5 -> Hazard_o=1 this cycle; next cycle IDEX_valid_o=0, controls 0, bubble_cnt_o=1; following cycle add loads, Hazard_o=0.
REQ-024 RT-only match with ID_UsesRT_i=0 (e.g. addi RT=5 dest) -> Hazard_o=0, no bubble; lw with RT=0 and ID RS=0 -> Hazard_o=0.
REQ-025 Simultaneous flush_i=1 and load-use -> Hazard_o=0, bubble inserted, bubble_cnt_o unchanged; stall_ext_i=1 with load-use -> Hazard_o=0, all outputs held 3 cycles, then stall resolves as REQ-023.
REQ-026 Counter: preload 16'hFFFF via 65535 forced hazards, one more hazard -> stays 16'hFFFF; rst_i=1 during hazard -> all outputs 0 next edge, bubble_cnt_o=0.
